// File: rtl/rgb_pwm_driver.sv
// ============================================================================
// Module   : rgb_pwm_driver
// Brief    : Three-channel active-low PWM LED driver with brightness scaling
//            and glitch-free duty updates committed on period boundaries.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rgb_pwm_driver #(
    parameter int PWM_RESOLUTION = 8,
    parameter int PRESCALE       = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [PWM_RESOLUTION-1:0] in_r,
    input  logic [PWM_RESOLUTION-1:0] in_g,
    input  logic [PWM_RESOLUTION-1:0] in_b,
    input  logic [PWM_RESOLUTION-1:0] brightness,
    output logic                      RGB_R,
    output logic                      RGB_G,
    output logic                      RGB_B,
    output logic                      frame_start
);

    localparam int c_N     = PWM_RESOLUTION;
    localparam int c_PROD  = 2 * PWM_RESOLUTION + 1;
    localparam int c_PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_N-1:0]    c_MAX     = '1;
    localparam logic [c_PS_W-1:0] c_PS_LAST = c_PS_W'(PRESCALE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCALE = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [c_PS_W-1:0]   r_ps;
    logic [c_N-1:0]      r_cnt;
    logic [2:0][c_N-1:0] r_raw;
    logic [c_N-1:0]      r_bright;
    logic [2:0][c_N-1:0] r_pend;
    logic [2:0][c_N-1:0] r_duty;
    logic [2:0]          w_drive;
    logic                w_tick;
    logic                w_boundary;
    logic                w_accept;

    // Full-width product so the brightness+1 term cannot overflow before the shift
    function automatic logic [c_N-1:0] f_scale(input logic [c_N-1:0] lvl,
                                               input logic [c_N-1:0] br);
        logic [c_PROD-1:0] p;
        p = c_PROD'(lvl) * (c_PROD'(br) + c_PROD'(1));
        return c_N'(p >> c_N);
    endfunction

    assign w_tick      = (r_ps == c_PS_LAST) && !reset;
    assign w_boundary  = w_tick && (r_cnt == c_MAX);
    assign frame_start = w_boundary;
    assign in_ready    = (r_state == S_IDLE) && !reset;
    assign w_accept    = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ps  <= '0;
            r_cnt <= '0;
        end else if (w_tick) begin
            r_ps  <= '0;
            r_cnt <= r_cnt + c_N'(1);
        end else begin
            r_ps  <= r_ps + c_PS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_SCALE;
            S_SCALE: w_next = S_HOLD;
            S_HOLD:  if (w_boundary) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_raw    <= '0;
            r_bright <= '0;
            r_pend   <= '0;
            r_duty   <= '0;
        end else begin
            if (w_accept) begin
                r_raw    <= {in_b, in_g, in_r};
                r_bright <= brightness;
            end
            if (r_state == S_SCALE) begin
                for (int k = 0; k < 3; k++) begin
                    r_pend[k] <= f_scale(r_raw[k], r_bright);
                end
            end
            // Commit only at the period boundary so a period never mixes old and new duty
            if ((r_state == S_HOLD) && w_boundary) begin
                r_duty <= r_pend;
            end
        end
    end

    generate
        for (genvar g = 0; g < 3; g++) begin : g_ch
            assign w_drive[g] = reset |
                                ~((r_duty[g] == c_MAX) || (r_cnt < r_duty[g]));
        end
    endgenerate

    assign RGB_R = w_drive[0];
    assign RGB_G = w_drive[1];
    assign RGB_B = w_drive[2];

endmodule

`default_nettype wire
